// File: rtl/plot_sink_if.sv
// Pixel-plot, clear and read-port signal bundle shared by a plot_sink and whatever drives it.
interface plot_sink_if;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        clear_req;
  logic [2:0]  clear_colour;
  logic        busy;
  logic        rd_req;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic        rd_valid;
  logic [2:0]  rd_colour;
  logic        rd_oob;
  logic [15:0] plot_count;
  logic [15:0] drop_count;
  logic [15:0] overplot_count;

  modport master (
    output vga_x, vga_y, vga_colour, vga_plot, clear_req, clear_colour,
           rd_req, rd_x, rd_y,
    input  busy, rd_valid, rd_colour, rd_oob, plot_count, drop_count, overplot_count
  );

  modport slave (
    input  vga_x, vga_y, vga_colour, vga_plot, clear_req, clear_colour,
           rd_req, rd_x, rd_y,
    output busy, rd_valid, rd_colour, rd_oob, plot_count, drop_count, overplot_count
  );
endinterface

// File: rtl/plot_sink.sv
// Framebuffer sink for the shape drawers: captures vga_plot writes, counts them, offers a 1-cycle read port.
// Optional per-pixel overplot tracking is enabled by defining PLOT_SINK_OVERPLOT_EN.
module plot_sink #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 120
) (
  input  logic       clk_i,
  input  logic       rst_i,
  plot_sink_if.slave bus
);
  localparam int unsigned DEPTH     = WIDTH * HEIGHT;
  localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);
  localparam logic [7:0]  X_LIM     = 8'(WIDTH);
  localparam logic [6:0]  Y_LIM     = 7'(HEIGHT);

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e      state_q, state_d;
  logic [14:0] ca_q, ca_d;
  logic [2:0]  fill_q, fill_d;
  logic [15:0] plot_cnt_q, plot_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_oob_q, rd_oob_d;
  logic [2:0]  rd_colour_q, rd_colour_d;

  logic [2:0]  mem_q [DEPTH];
  logic        we;
  logic [14:0] wa;
  logic [2:0]  wd;

  logic        plot_in, rd_in;
  logic [14:0] plot_addr, rd_addr;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign plot_in   = (bus.vga_x < X_LIM) && (bus.vga_y < Y_LIM);
  assign rd_in     = (bus.rd_x < X_LIM) && (bus.rd_y < Y_LIM);
  assign plot_addr = 15'(bus.vga_y) * 15'(WIDTH) + 15'(bus.vga_x);
  assign rd_addr   = 15'(bus.rd_y) * 15'(WIDTH) + 15'(bus.rd_x);

  always_comb begin
    state_d     = state_q;
    ca_d        = ca_q;
    fill_d      = fill_q;
    plot_cnt_d  = plot_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    rd_valid_d  = 1'b0;
    rd_oob_d    = 1'b0;
    rd_colour_d = rd_colour_q;
    we          = 1'b0;
    wa          = plot_addr;
    wd          = bus.vga_colour;
    case (state_q)
      S_CLEAR: begin
        we = 1'b1;
        wa = ca_q;
        wd = fill_q;
        if (bus.vga_plot) drop_cnt_d = sat_inc(drop_cnt_q);
        if (ca_q == LAST_ADDR) state_d = S_READY;
        else                   ca_d    = ca_q + 15'd1;
      end
      S_READY: begin
        // Read-first: the array value seen here predates this cycle's write.
        if (bus.rd_req) begin
          rd_valid_d  = 1'b1;
          rd_oob_d    = !rd_in;
          rd_colour_d = rd_in ? mem_q[rd_addr] : 3'd0;
        end
        if (bus.vga_plot) begin
          if (plot_in) begin
            we         = 1'b1;
            plot_cnt_d = sat_inc(plot_cnt_q);
          end else begin
            drop_cnt_d = sat_inc(drop_cnt_q);
          end
        end
        // A plot alongside clear_req is still written, but the fill overwrites it and it goes uncounted.
        if (bus.clear_req) begin
          fill_d     = bus.clear_colour;
          plot_cnt_d = '0;
          drop_cnt_d = '0;
          ca_d       = '0;
          state_d    = S_CLEAR;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_CLEAR;
      ca_q        <= '0;
      fill_q      <= '0;
      plot_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_oob_q    <= 1'b0;
      rd_colour_q <= '0;
    end else begin
      state_q     <= state_d;
      ca_q        <= ca_d;
      fill_q      <= fill_d;
      plot_cnt_q  <= plot_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_oob_q    <= rd_oob_d;
      rd_colour_q <= rd_colour_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[wa] <= wd;
  end

`ifdef PLOT_SINK_OVERPLOT_EN
  logic        flag_q [DEPTH];
  logic [15:0] over_q, over_d;
  logic        plot_ok, clr_go;

  assign plot_ok = (state_q == S_READY) && bus.vga_plot && plot_in;
  assign clr_go  = (state_q == S_READY) && bus.clear_req;

  // Fill writes clear the flag, plot writes set it.
  always_ff @(posedge clk_i) begin
    if (we) flag_q[wa] <= (state_q == S_READY);
  end

  always_comb begin
    over_d = over_q;
    if (clr_go)                           over_d = '0;
    else if (plot_ok && flag_q[plot_addr]) over_d = sat_inc(over_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) over_q <= '0;
    else       over_q <= over_d;
  end

  assign bus.overplot_count = over_q;
`else
  assign bus.overplot_count = '0;
`endif

  assign bus.busy       = (state_q == S_CLEAR);
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_oob     = rd_oob_q;
  assign bus.rd_colour  = rd_colour_q;
  assign bus.plot_count = plot_cnt_q;
  assign bus.drop_count = drop_cnt_q;
endmodule

// File: tb/tb_plot_sink.sv
// Self-checking bench for plot_sink: directed scenarios plus randomized plots/reads against a framebuffer model.
module tb_plot_sink;
  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  plot_sink_if bus();
  plot_sink dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Behavioural model: a plain framebuffer, a clear that lands all at once after N cycles, and counters.
  int   m_mem  [N];
  bit   m_flag [N];
  bit   m_live = 0;
  bit   m_busy;
  int   m_left;
  int   m_fill;
  int   m_plot, m_drop, m_over;
  int   e_valid, e_colour, e_oob;

  function automatic int sat(input int v);
    return (v == 65535) ? v : v + 1;
  endfunction

  task automatic model_step();
    int a;
    if (rst) begin
      m_live = 1; m_busy = 1; m_left = N; m_fill = 0;
      m_plot = 0; m_drop = 0; m_over = 0;
      e_valid = 0; e_colour = 0; e_oob = 0;
      return;
    end
    if (!m_live) return;
    if (m_busy) begin
      if (bus.vga_plot) m_drop = sat(m_drop);
      e_valid = 0; e_oob = 0;
      m_left--;
      if (m_left == 0) begin
        for (int i = 0; i < N; i++) begin m_mem[i] = m_fill; m_flag[i] = 0; end
        m_busy = 0;
      end
      return;
    end
    if (bus.rd_req) begin
      e_valid = 1;
      if (bus.rd_x < W && bus.rd_y < H) begin
        e_colour = m_mem[bus.rd_y * W + bus.rd_x]; e_oob = 0;
      end else begin
        e_colour = 0; e_oob = 1;
      end
    end else begin
      e_valid = 0; e_oob = 0;
    end
    if (bus.vga_plot) begin
      if (bus.vga_x < W && bus.vga_y < H) begin
        a = bus.vga_y * W + bus.vga_x;
        if (!bus.clear_req) begin
          m_plot = sat(m_plot);
          if (m_flag[a]) m_over = sat(m_over);
        end
        m_mem[a] = bus.vga_colour;
        m_flag[a] = 1;
      end else if (!bus.clear_req) begin
        m_drop = sat(m_drop);
      end
    end
    if (bus.clear_req) begin
      m_fill = bus.clear_colour;
      m_plot = 0; m_drop = 0; m_over = 0;
      m_busy = 1; m_left = N;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    int exp_over;
    @(negedge clk);
    if (m_live) begin
`ifdef PLOT_SINK_OVERPLOT_EN
      exp_over = m_over;
`else
      exp_over = 0;
`endif
      check("busy",     32'(bus.busy),           32'(m_busy));
      check("plot_cnt", 32'(bus.plot_count),     32'(m_plot));
      check("drop_cnt", 32'(bus.drop_count),     32'(m_drop));
      check("over_cnt", 32'(bus.overplot_count), 32'(exp_over));
      check("rd_valid", 32'(bus.rd_valid),       32'(e_valid));
      check("rd_oob",   32'(bus.rd_oob),         32'(e_oob));
      check("rd_colour",32'(bus.rd_colour),      32'(e_colour));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.vga_x = 0; bus.vga_y = 0; bus.vga_colour = 0; bus.vga_plot = 0;
    bus.clear_req = 0; bus.clear_colour = 0;
    bus.rd_req = 0; bus.rd_x = 0; bus.rd_y = 0;
  endtask

  task automatic plot(input int x, input int y, input int c);
    bus.vga_x = 8'(x); bus.vga_y = 7'(y); bus.vga_colour = 3'(c); bus.vga_plot = 1;
    tick();
    bus.vga_plot = 0;
  endtask

  task automatic read_chk(input string name, input int x, input int y, input int ec, input int eo);
    bus.rd_x = 8'(x); bus.rd_y = 7'(y); bus.rd_req = 1;
    tick();
    bus.rd_req = 0;
    check({name, "_valid"},  32'(bus.rd_valid),  32'd1);
    check({name, "_colour"}, 32'(bus.rd_colour), 32'(ec));
    check({name, "_oob"},    32'(bus.rd_oob),    32'(eo));
  endtask

  // Counts cycles with busy high; optionally pokes a plot and an ignored clear_req mid-fill.
  task automatic wait_busy(output int cnt, input bit inject);
    cnt = 0;
    while (bus.busy && cnt < 25000) begin
      if (inject && cnt == 100) begin
        bus.vga_x = 1; bus.vga_y = 1; bus.vga_colour = 7; bus.vga_plot = 1;
      end
      if (inject && cnt == 200) begin
        bus.clear_req = 1; bus.clear_colour = 2;
      end
      cnt++;
      tick();
      bus.vga_plot = 0; bus.clear_req = 0;
    end
    if (cnt >= 25000) check("busy_timeout", 32'(cnt), 32'd19200);
  endtask

  initial begin
    int cnt;
    idle();
    rst = 1;
    tick();
    rst = 0;
    wait_busy(cnt, 0);
    check("powerup_busy_cycles", 32'(cnt), 32'd19200);
    read_chk("rd00", 0, 0, 0, 0);
    read_chk("rd159_119", 159, 119, 0, 0);

    plot(5, 7, 3);
    read_chk("rd5_7", 5, 7, 3, 0);
    check("plot_cnt_1", 32'(bus.plot_count), 32'd1);
    check("drop_cnt_0", 32'(bus.drop_count), 32'd0);

    plot(160, 0, 4);
    plot(0, 120, 4);
    tick();
    check("drop_cnt_2", 32'(bus.drop_count), 32'd2);
    check("plot_cnt_still1", 32'(bus.plot_count), 32'd1);
    read_chk("rd00_after_oob", 0, 0, 0, 0);
    read_chk("rd_oob_200_50", 200, 50, 0, 1);

    plot(3, 4, 1);
    plot(3, 4, 2);
    tick();
`ifdef PLOT_SINK_OVERPLOT_EN
    check("overplot_1", 32'(bus.overplot_count), 32'd1);
`else
    check("overplot_0", 32'(bus.overplot_count), 32'd0);
`endif

    plot(10, 10, 3);
    bus.vga_x = 10; bus.vga_y = 10; bus.vga_colour = 6; bus.vga_plot = 1;
    bus.rd_x = 10; bus.rd_y = 10; bus.rd_req = 1;
    tick();
    bus.vga_plot = 0; bus.rd_req = 0;
    check("collide_old", 32'(bus.rd_colour), 32'd3);
    read_chk("collide_new", 10, 10, 6, 0);

    bus.clear_req = 1; bus.clear_colour = 5;
    tick();
    bus.clear_req = 0;
    wait_busy(cnt, 1);
    check("clear_busy_cycles", 32'(cnt), 32'd19200);
    check("clear_drop_1", 32'(bus.drop_count), 32'd1);
    check("clear_plot_0", 32'(bus.plot_count), 32'd0);
    check("clear_over_0", 32'(bus.overplot_count), 32'd0);
    for (int i = 0; i < 8; i++)
      read_chk("rd_after_clear5", $urandom_range(0, W - 1), $urandom_range(0, H - 1), 5, 0);

    for (int i = 0; i < 3000; i++) begin
      bus.vga_plot   = ($urandom_range(0, 3) != 0);
      bus.vga_x      = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 15));
      bus.vga_y      = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(120, 127)) : 7'($urandom_range(0, 7));
      bus.vga_colour = 3'($urandom_range(0, 7));
      bus.rd_req     = ($urandom_range(0, 2) != 0);
      bus.rd_x       = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 15));
      bus.rd_y       = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(120, 127)) : 7'($urandom_range(0, 7));
      tick();
    end
    idle();
    tick();

    plot(1, 1, 7);
    bus.vga_x = 2; bus.vga_y = 2; bus.vga_colour = 7; bus.vga_plot = 1;
    bus.clear_req = 1; bus.clear_colour = 3;
    tick();
    idle();
    repeat (5000) tick();
    rst = 1;
    tick();
    rst = 0;
    wait_busy(cnt, 0);
    check("rst_midclear_busy_cycles", 32'(cnt), 32'd19200);
    check("rst_midclear_plot_0", 32'(bus.plot_count), 32'd0);
    read_chk("rd1_1_after_rst", 1, 1, 0, 0);
    read_chk("rd2_2_after_rst", 2, 2, 0, 0);
    for (int i = 0; i < 6; i++)
      read_chk("rd_after_rst", $urandom_range(0, W - 1), $urandom_range(0, H - 1), 0, 0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/plot_sink.md
# plot_sink

Receiving end of the pixel-plot stream produced by the shape drawers (circle, reuleaux, triangle): captures every `vga_plot` write into an internal WIDTH×HEIGHT colour framebuffer and counts accepted and dropped writes. Exposes a one-cycle-latency random read port so a bench or a scan-out stage can inspect what a drawer actually plotted. It sits where the VGA adaptor would be, as a synthesizable, cycle-exact stand-in for it.

## Interface
- `WIDTH`, 160, framebuffer columns
- `HEIGHT`, 120, framebuffer rows
- `clk`  in  1  sole clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `vga_x`  in  8  plot column
- `vga_y`  in  7  plot row
- `vga_colour`  in  3  plot colour
- `vga_plot`  in  1  write strobe; one pixel per cycle high
- `clear_req`  in  1  one-cycle request to fill the framebuffer
- `clear_colour`  in  3  fill colour, sampled with `clear_req`
- `busy`  out  1  high while clearing
- `rd_req`  in  1  read request
- `rd_x`  in  8  read column
- `rd_y`  in  7  read row
- `rd_valid`  out  1  read data valid, one cycle after `rd_req`
- `rd_colour`  out  3  read data
- `rd_oob`  out  1  qualifies `rd_valid`: requested coordinate was out of range
- `plot_count`  out  16  accepted plots since last clear, saturating
- `drop_count`  out  16  rejected plots since last clear, saturating
- `overplot_count`  out  16  plots to already-written pixels (see Configuration)

## Operation
- Storage: WIDTH*HEIGHT×3 simple dual-port memory, addr = y*WIDTH + x (15 bits). Write port shared by plot and clear; read port dedicated; read-first.
- FSM states: CLEAR, READY.
- CLEAR:
  - Fill counter `ca` runs 0 to WIDTH*HEIGHT−1, writing the latched fill colour at one address per cycle.
  - After the write at the last address, go to READY.
  - `busy`=1 throughout.
  - Any `vga_plot` increments `drop_count` and nothing is written.
  - `rd_req` and `clear_req` are ignored.
- READY:
  - A plot with `vga_plot`=1 and x<WIDTH and y<HEIGHT writes `vga_colour` and increments `plot_count`.
  - A plot with `vga_plot`=1 that is out of range writes nothing and increments `drop_count`.
  - `clear_req`=1 latches `clear_colour`, zeroes all three counters, sets `ca`=0 and enters CLEAR next cycle.
  - A plot in the same cycle as `clear_req` is performed and then discarded: it is written but overwritten by the clear, and it is not counted.
- Read port (READY only):
  - `rd_req` in cycle N gives `rd_valid`=1 in cycle N+1.
  - In range: `rd_colour` = memory contents before any write in cycle N, and `rd_oob`=0.
  - Out of range: `rd_colour`=0 and `rd_oob`=1.
  - Without `rd_req`: `rd_valid`=0, `rd_oob`=0, and `rd_colour` holds its value.
- Counters saturate at 16'hFFFF and do not wrap.

## Timing
- Reset values (cycle after `rst` sampled high):
  - state=CLEAR, fill colour=0, `ca`=0, `busy`=1
  - `rd_valid`=0, `rd_colour`=0, `rd_oob`=0
  - all counters=0
- Power-up clear takes WIDTH*HEIGHT cycles (19200 at defaults). `busy` falls in the cycle after the last fill write.
- `rst` during CLEAR restarts the fill from address 0 with colour 0. `rst` during READY behaves the same.
- Plot-to-read latency:
  - A plot at cycle N is visible to an `rd_req` at cycle N+1.
  - An `rd_req` at cycle N to the same address returns the old value.
- Throughput: one plot and one read per cycle, sustained.
- `clear_req` while `busy` is ignored and the fill colour is not re-latched.

## Configuration
- `PLOT_SINK_OVERPLOT_EN` defined:
  - Adds a 1-bit written-flag per pixel, cleared alongside the colour during CLEAR.
  - An accepted plot to a pixel whose flag is set increments `overplot_count` (saturating); every accepted plot sets the flag.
- `PLOT_SINK_OVERPLOT_EN` undefined: no flag storage, and `overplot_count` is tied to 0.

## Test plan
- Power-up: pulse `rst` for 1 cycle.
  - `busy` is high for exactly 19200 cycles.
  - Then `rd_req` at (0,0) and at (159,119) each return `rd_colour`=0, `rd_oob`=0 one cycle later.
- In-range plot: plot (5,7) colour 3, then read (5,7) next cycle.
  - Read returns 3; `plot_count`=1, `drop_count`=0.
- Out-of-range plots: plot (160,0) and (0,120).
  - `drop_count`=2, `plot_count` unchanged, reads of (0,0) unaffected.
  - Read (200,50) returns `rd_valid`=1, `rd_oob`=1, `rd_colour`=0.
- Read-first collision: with (10,10)=3, plot (10,10) colour 6 and `rd_req` (10,10) in the same cycle.
  - That read returns 3; a read next cycle returns 6.
- Clear: `clear_req` with `clear_colour`=5 in READY.
  - `busy` is high 19200 cycles; a plot during busy raises `drop_count` to 1.
  - Afterwards random reads return 5; `plot_count`=0.
  - `rst` asserted mid-clear restarts the fill and the final contents are 0.
- Overplot: plot (3,4) twice.
  - With `PLOT_SINK_OVERPLOT_EN`: `overplot_count`=1, and 0 after a clear.
  - Without the macro: `overplot_count`=0.
